// File: rtl/arith_mod_red_solinas2.sv
// -----------------------------------------------------------------------------
// arith_mod_red_solinas2_pkg / arith_mod_red_solinas2
//
// Pipelined reducer of a 2*MOD_W-bit value modulo the Solinas prime
// 2^MOD_W - 2^INT_POW + 1, using three folding stages
// (2^MOD_W == 2^INT_POW - 1 modulo that prime) followed by
// one conditional subtraction. Latency is IN_PIPE + 4 cycles, full
// throughput, no backpressure. A side-band word travels with each item.
//
// Ports:
//   clk        clock
//   a_rst      asynchronous reset, active-high
//   a          [2*MOD_W] value to reduce
//   in_avail   a / in_side valid this cycle
//   in_side    [SIDE_W] side-band accompanying a
//   z          [MOD_W] a reduced modulo the prime
//   out_avail  z / out_side valid
//   out_side   [SIDE_W] in_side delayed by the pipeline latency
//   err        (only with ARITH_MOD_RED_SOLINAS2_CHECK_EN) sticky flag set
//              when z disagrees with a behavioural shadow pipeline
//
// Optional feature macro: ARITH_MOD_RED_SOLINAS2_CHECK_EN
// -----------------------------------------------------------------------------
package arith_mod_red_solinas2_pkg;
   // Core latency in cycles, not counting the optional input register.
   function automatic int get_latency();
      return 4;
   endfunction
endpackage

module arith_mod_red_solinas2 #(
   parameter int         MOD_W    = 64,
   parameter int         INT_POW  = 32,
   parameter int         IN_PIPE  = 1,
   parameter int         SIDE_W   = 8,
   parameter logic [1:0] RST_SIDE = 2'b00
) (
   input  logic                 clk,
   input  logic                 a_rst,
   input  logic [2*MOD_W-1:0]   a,
   input  logic                 in_avail,
   input  logic [SIDE_W-1:0]    in_side,
   output logic [MOD_W-1:0]     z,
   output logic                 out_avail,
   output logic [SIDE_W-1:0]    out_side
`ifdef ARITH_MOD_RED_SOLINAS2_CHECK_EN
   ,
   output logic                 err
`endif
);

   localparam int LAT = IN_PIPE + arith_mod_red_solinas2_pkg::get_latency();
   localparam int W1  = MOD_W + INT_POW + 1;  // after first fold
   localparam int W2  = MOD_W + 2;            // after second fold
   localparam int W3  = MOD_W + 1;            // after third fold, < 2*MOD
   localparam logic [MOD_W-1:0] LSB = MOD_W'(1);
   localparam logic [MOD_W-1:0] MOD = {{(MOD_W-INT_POW){1'b1}}, {INT_POW{1'b0}}} | LSB;

   generate
      if (MOD_W < 8) begin : g_bad_mod_w
         $fatal(1, "arith_mod_red_solinas2: MOD_W must be >= 8");
      end
      if (INT_POW < 1 || INT_POW > MOD_W/2) begin : g_bad_int_pow
         $fatal(1, "arith_mod_red_solinas2: INT_POW must be in [1, MOD_W/2]");
      end
      if (IN_PIPE != 0 && IN_PIPE != 1) begin : g_bad_in_pipe
         $fatal(1, "arith_mod_red_solinas2: IN_PIPE must be 0 or 1");
      end
   endgenerate

   // ---------------------------------------------------------------- avail
   // vld[i] marks valid data at the output of register stage i; en[i] is the
   // load enable of stage i (its input is valid).
   logic [LAT-1:0] vld;
   logic [LAT-1:0] en;

   assign en = {vld[LAT-2:0], in_avail};

   // NOTE: state registers use non-blocking assignments so every stage
   // samples the pre-edge value of its neighbour, giving a true shift.
   always_ff @(posedge clk or posedge a_rst) begin
      if (a_rst) vld <= '0;
      else       vld <= en;
   end

   assign out_avail = vld[LAT-1];

   // ---------------------------------------------------------- input stage
   logic [2*MOD_W-1:0] x;

   generate
      if (IN_PIPE == 1) begin : g_in_reg
         logic [2*MOD_W-1:0] a_q;
         // NOTE: wide data registers carry no reset; the avail chain alone
         // decides whether their contents mean anything.
         always_ff @(posedge clk) begin
            if (in_avail) a_q <= a;
         end
         assign x = a_q;
      end else begin : g_in_comb
         assign x = a;
      end
   endgenerate

   // ------------------------------------------------------------- folds
   // Each fold rewrites hi*2^MOD_W + lo as lo + hi*2^INT_POW - hi. The add
   // happens before the subtract so the intermediate never goes negative.
   logic [W1-1:0] t1_d, t1_q;
   logic [W2-1:0] t2_d, t2_q;
   logic [W3-1:0] t3_d, t3_q;

   assign t1_d = W1'(x[MOD_W-1:0])
               + (W1'(x[2*MOD_W-1:MOD_W]) << INT_POW)
               - W1'(x[2*MOD_W-1:MOD_W]);

   assign t2_d = W2'(t1_q[MOD_W-1:0])
               + (W2'(t1_q[W1-1:MOD_W]) << INT_POW)
               - W2'(t1_q[W1-1:MOD_W]);

   assign t3_d = W3'(t2_q[MOD_W-1:0])
               + (W3'(t2_q[W2-1:MOD_W]) << INT_POW)
               - W3'(t2_q[W2-1:MOD_W]);

   always_ff @(posedge clk) begin
      if (en[IN_PIPE])     t1_q <= t1_d;
      if (en[IN_PIPE + 1]) t2_q <= t2_d;
      if (en[IN_PIPE + 2]) t3_q <= t3_d;
   end

   // ----------------------------------------------- final correction stage
   // t3 < 2*MOD, so a single conditional subtraction lands in [0, MOD-1].
   logic [MOD_W-1:0] z_d;

   assign z_d = (t3_q >= {1'b0, MOD}) ? MOD_W'(t3_q - {1'b0, MOD})
                                      : t3_q[MOD_W-1:0];

   always_ff @(posedge clk or posedge a_rst) begin
      if (a_rst)                z <= '0;
      else if (en[IN_PIPE + 3]) z <= z_d;
   end

   // ----------------------------------------------------------- side-band
   generate
      if (SIDE_W > 0) begin : g_side
         logic [SIDE_W-1:0] side_q [LAT];
         logic [SIDE_W-1:0] side_d [LAT];

         always_comb begin
            side_d[0] = in_side;
            for (int i = 1; i < LAT; i++) side_d[i] = side_q[i-1];
         end

         if (RST_SIDE[0]) begin : g_rst
            always_ff @(posedge clk or posedge a_rst) begin
               if (a_rst) begin
                  for (int i = 0; i < LAT; i++) side_q[i] <= {SIDE_W{RST_SIDE[1]}};
               end else begin
                  for (int i = 0; i < LAT; i++) if (en[i]) side_q[i] <= side_d[i];
               end
            end
         end else begin : g_norst
            always_ff @(posedge clk) begin
               for (int i = 0; i < LAT; i++) if (en[i]) side_q[i] <= side_d[i];
            end
         end

         assign out_side = side_q[LAT-1];
      end else begin : g_noside
         assign out_side = '0;
      end
   endgenerate

`ifdef ARITH_MOD_RED_SOLINAS2_CHECK_EN
   // ------------------------------------------------------ shadow checker
   // Straight a % MOD computed at the input and carried alongside the real
   // pipeline so it lines up with out_avail.
   localparam int AW = 2 * MOD_W;

   logic [MOD_W-1:0] sh_q [LAT];
   logic [MOD_W-1:0] sh_d [LAT];

   always_comb begin
      sh_d[0] = MOD_W'(a % AW'(MOD));
      for (int i = 1; i < LAT; i++) sh_d[i] = sh_q[i-1];
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < LAT; i++) if (en[i]) sh_q[i] <= sh_d[i];
   end

   always_ff @(posedge clk or posedge a_rst) begin
      if (a_rst) begin
         err <= 1'b0;
      end else if (out_avail && (z != sh_q[LAT-1])) begin
         err <= 1'b1;
         $display("arith_mod_red_solinas2: result mismatch z=%h shadow=%h",
                  z, sh_q[LAT-1]);
      end
   end
`endif

endmodule

// File: tb/tb_arith_mod_red_solinas2.sv
// -----------------------------------------------------------------------------
// tb_arith_mod_red_solinas2
//
// Two instances share clock and reset:
//   dut_a: MOD_W=64, INT_POW=32, IN_PIPE=1 (LAT=5), SIDE_W=8, RST_SIDE=2'b11
//   dut_b: MOD_W=32, INT_POW=16, IN_PIPE=0 (LAT=4), SIDE_W=4, RST_SIDE=2'b01
// Inputs change on the falling edge; outputs are sampled on the falling edge
// before new inputs are applied, so an item driven at falling edge k is seen
// at falling edge k+LAT. Expected results come from plain a % MOD.
// -----------------------------------------------------------------------------
module tb_arith_mod_red_solinas2;

   localparam int          LAT_A = 5;
   localparam int          LAT_B = 4;
   localparam logic [63:0] MOD_A = 64'hFFFF_FFFF_0000_0001;
   localparam logic [31:0] MOD_B = 32'hFFFF_0001;
   localparam int          NR    = 3000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         a_rst = 1'b1;

   logic [127:0] a_a    = '0;
   logic         av_a   = 1'b0;
   logic [7:0]   side_a = '0;
   logic [63:0]  z_a;
   logic         oav_a;
   logic [7:0]   os_a;

   logic [63:0]  a_b    = '0;
   logic         av_b   = 1'b0;
   logic [3:0]   side_b = '0;
   logic [31:0]  z_b;
   logic         oav_b;
   logic [3:0]   os_b;

`ifdef ARITH_MOD_RED_SOLINAS2_CHECK_EN
   logic err_a, err_b;
`endif

   int checks = 0;
   int errors = 0;

   arith_mod_red_solinas2 #(
      .MOD_W(64), .INT_POW(32), .IN_PIPE(1), .SIDE_W(8), .RST_SIDE(2'b11)
   ) dut_a (
      .clk(clk), .a_rst(a_rst), .a(a_a), .in_avail(av_a), .in_side(side_a),
      .z(z_a), .out_avail(oav_a), .out_side(os_a)
`ifdef ARITH_MOD_RED_SOLINAS2_CHECK_EN
      , .err(err_a)
`endif
   );

   arith_mod_red_solinas2 #(
      .MOD_W(32), .INT_POW(16), .IN_PIPE(0), .SIDE_W(4), .RST_SIDE(2'b01)
   ) dut_b (
      .clk(clk), .a_rst(a_rst), .a(a_b), .in_avail(av_b), .in_side(side_b),
      .z(z_b), .out_avail(oav_b), .out_side(os_b)
`ifdef ARITH_MOD_RED_SOLINAS2_CHECK_EN
      , .err(err_b)
`endif
   );

   // ------------------------------------------------------ reference model
   function automatic logic [63:0] ref_a(input logic [127:0] v);
      logic [127:0] r;
      r = v % {64'd0, MOD_A};
      return r[63:0];
   endfunction

   function automatic logic [31:0] ref_b(input logic [63:0] v);
      logic [63:0] r;
      r = v % {32'd0, MOD_B};
      return r[31:0];
   endfunction

   function automatic logic [127:0] rand_a();
      logic [127:0] v;
      int sel;
      sel = $urandom_range(0, 9);
      v   = {$urandom, $urandom, $urandom, $urandom};
      case (sel)
         0: v = '1;
         1: v = {64'd0, MOD_A} * {96'd0, v[31:0]};
         2: v = {64'd0, MOD_A} - 128'd1 + 128'($urandom_range(0, 2));
         default: ;
      endcase
      return v;
   endfunction

   function automatic logic [63:0] rand_b();
      logic [63:0] v;
      int sel;
      sel = $urandom_range(0, 9);
      v   = {$urandom, $urandom};
      case (sel)
         0: v = '1;
         1: v = {32'd0, MOD_B} * {48'd0, v[15:0]};
         2: v = {32'd0, MOD_B} - 64'd1 + 64'($urandom_range(0, 2));
         default: ;
      endcase
      return v;
   endfunction

   // ------------------------------------------------------------ scenarios
   task automatic test_reset();
      a_rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (oav_a !== 1'b0) begin errors++; $display("FAIL reset_oav_a got %0b want 0", oav_a); end
      checks++; if (z_a !== 64'd0) begin errors++; $display("FAIL reset_z_a got %h want 0", z_a); end
      checks++; if (os_a !== 8'hFF) begin errors++; $display("FAIL reset_side_a got %h want ff", os_a); end
      checks++; if (oav_b !== 1'b0) begin errors++; $display("FAIL reset_oav_b got %0b want 0", oav_b); end
      checks++; if (z_b !== 32'd0) begin errors++; $display("FAIL reset_z_b got %h want 0", z_b); end
      checks++; if (os_b !== 4'h0) begin errors++; $display("FAIL reset_side_b got %h want 0", os_b); end
      a_rst = 1'b0;
      repeat (LAT_A + 1) @(negedge clk);
      checks++; if (oav_a !== 1'b0 || oav_b !== 1'b0) begin
         errors++; $display("FAIL idle_after_reset got a=%0b b=%0b want 0 0", oav_a, oav_b);
      end
   endtask

   task automatic test_boundary();
      logic [127:0] vec [6];
      logic [63:0]  exp [6];
      logic [127:0] m;
      m      = {64'd0, MOD_A};
      vec[0] = 128'd0;               exp[0] = 64'd0;
      vec[1] = m;                    exp[1] = 64'd0;
      vec[2] = m - 128'd1;           exp[2] = 64'hFFFF_FFFF_0000_0000;
      vec[3] = 128'd1 << 64;         exp[3] = 64'h0000_0000_FFFF_FFFF;
      vec[4] = '1;                   exp[4] = 64'hFFFF_FFFE_0000_0000;
      vec[5] = m * m + 128'd5;       exp[5] = 64'd5;
      for (int k = 0; k <= 6 + LAT_A; k++) begin
         @(negedge clk);
         if (k >= LAT_A && k - LAT_A < 6) begin
            checks++; if (oav_a !== 1'b1) begin errors++; $display("FAIL boundary_avail[%0d] got %0b want 1", k - LAT_A, oav_a); end
            checks++; if (z_a !== exp[k - LAT_A]) begin
               errors++; $display("FAIL boundary_z[%0d] got %h want %h", k - LAT_A, z_a, exp[k - LAT_A]);
            end
         end else begin
            checks++; if (oav_a !== 1'b0) begin errors++; $display("FAIL boundary_idle cycle %0d got %0b want 0", k, oav_a); end
         end
         if (k < 6) begin av_a = 1'b1; a_a = vec[k]; end
         else begin av_a = 1'b0; a_a = {$urandom, $urandom, $urandom, $urandom}; end
      end
      checks++; if (z_a !== exp[5]) begin errors++; $display("FAIL boundary_hold got %h want %h", z_a, exp[5]); end
   endtask

   task automatic test_bubbles();
      logic [5:0]   pat;
      logic [127:0] d [6];
      logic [7:0]   got [$];
      logic [7:0]   sd;
      pat = 6'b101101;   // cycle order 1,0,1,1,0,1
      for (int i = 0; i < 6; i++) d[i] = rand_a();
      for (int k = 0; k <= 6 + LAT_A; k++) begin
         @(negedge clk);
         if (k >= LAT_A && k - LAT_A < 6) begin
            checks++; if (oav_a !== pat[k - LAT_A]) begin
               errors++; $display("FAIL bubble_avail[%0d] got %0b want %0b", k - LAT_A, oav_a, pat[k - LAT_A]);
            end
            if (pat[k - LAT_A]) begin
               sd = 8'h11 + 8'(k - LAT_A);
               checks++; if (z_a !== ref_a(d[k - LAT_A])) begin
                  errors++; $display("FAIL bubble_z[%0d] got %h want %h", k - LAT_A, z_a, ref_a(d[k - LAT_A]));
               end
               checks++; if (os_a !== sd) begin
                  errors++; $display("FAIL bubble_side[%0d] got %h want %h", k - LAT_A, os_a, sd);
               end
            end
         end else begin
            checks++; if (oav_a !== 1'b0) begin errors++; $display("FAIL bubble_idle cycle %0d got %0b want 0", k, oav_a); end
         end
         if (oav_a === 1'b1) got.push_back(os_a);
         if (k < 6) begin av_a = pat[k]; a_a = d[k]; side_a = 8'h11 + 8'(k); end
         else begin av_a = 1'b0; side_a = 8'($urandom); end
      end
      checks++;
      if (got.size() != 4) begin
         errors++; $display("FAIL bubble_count got %0d want 4", got.size());
      end else if ({got[0], got[1], got[2], got[3]} !== 32'h11131416) begin
         errors++; $display("FAIL bubble_order got %h want 11131416", {got[0], got[1], got[2], got[3]});
      end
   endtask

   task automatic test_reset_midstream();
      logic [127:0] d;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         av_a = 1'b1; a_a = rand_a(); side_a = 8'h30 + 8'(k);
      end
      @(negedge clk);
      av_a  = 1'b0;
      a_rst = 1'b1;
      #1;
      checks++; if (oav_a !== 1'b0) begin errors++; $display("FAIL midrst_avail got %0b want 0", oav_a); end
      checks++; if (os_a !== 8'hFF) begin errors++; $display("FAIL midrst_side got %h want ff", os_a); end
      checks++; if (z_a !== 64'd0) begin errors++; $display("FAIL midrst_z got %h want 0", z_a); end
      @(negedge clk);
      a_rst = 1'b0;
      for (int k = 0; k < LAT_A + 3; k++) begin
         @(negedge clk);
         checks++; if (oav_a !== 1'b0) begin errors++; $display("FAIL midrst_stale cycle %0d got %0b want 0", k, oav_a); end
      end
      d = rand_a();
      av_a = 1'b1; a_a = d; side_a = 8'h5A;
      for (int k = 1; k <= LAT_A; k++) begin
         @(negedge clk);
         if (k < LAT_A) begin
            checks++; if (oav_a !== 1'b0) begin errors++; $display("FAIL midrst_early cycle %0d got %0b want 0", k, oav_a); end
         end else begin
            checks++; if (oav_a !== 1'b1) begin errors++; $display("FAIL midrst_latency got %0b want 1", oav_a); end
            checks++; if (z_a !== ref_a(d)) begin errors++; $display("FAIL midrst_z got %h want %h", z_a, ref_a(d)); end
            checks++; if (os_a !== 8'h5A) begin errors++; $display("FAIL midrst_side_out got %h want 5a", os_a); end
         end
         av_a = 1'b0;
      end
   endtask

   task automatic test_random();
      logic        hv_a [NR];
      logic [63:0] hz_a [NR];
      logic [7:0]  hs_a [NR];
      logic        hv_b [NR];
      logic [31:0] hz_b [NR];
      logic [3:0]  hs_b [NR];
      logic        ev;
      for (int k = 0; k < NR + LAT_A; k++) begin
         @(negedge clk);
         ev = (k >= LAT_A) ? hv_a[k - LAT_A] : 1'b0;
         checks++; if (oav_a !== ev) begin errors++; $display("FAIL rand_avail_a cycle %0d got %0b want %0b", k, oav_a, ev); end
         if (ev) begin
            checks++; if (z_a !== hz_a[k - LAT_A]) begin
               errors++; $display("FAIL rand_z_a cycle %0d got %h want %h", k, z_a, hz_a[k - LAT_A]);
            end
            checks++; if (os_a !== hs_a[k - LAT_A]) begin
               errors++; $display("FAIL rand_side_a cycle %0d got %h want %h", k, os_a, hs_a[k - LAT_A]);
            end
         end
         ev = (k >= LAT_B && k - LAT_B < NR) ? hv_b[k - LAT_B] : 1'b0;
         checks++; if (oav_b !== ev) begin errors++; $display("FAIL rand_avail_b cycle %0d got %0b want %0b", k, oav_b, ev); end
         if (ev) begin
            checks++; if (z_b !== hz_b[k - LAT_B]) begin
               errors++; $display("FAIL rand_z_b cycle %0d got %h want %h", k, z_b, hz_b[k - LAT_B]);
            end
            checks++; if (os_b !== hs_b[k - LAT_B]) begin
               errors++; $display("FAIL rand_side_b cycle %0d got %h want %h", k, os_b, hs_b[k - LAT_B]);
            end
         end
         if (k < NR) begin
            av_a = ($urandom_range(0, 3) != 0); a_a = rand_a(); side_a = 8'($urandom);
            av_b = ($urandom_range(0, 3) != 0); a_b = rand_b(); side_b = 4'($urandom);
            hv_a[k] = av_a; hz_a[k] = ref_a(a_a); hs_a[k] = side_a;
            hv_b[k] = av_b; hz_b[k] = ref_b(a_b); hs_b[k] = side_b;
         end else begin
            av_a = 1'b0; av_b = 1'b0;
         end
      end
`ifdef ARITH_MOD_RED_SOLINAS2_CHECK_EN
      checks++; if (err_a !== 1'b0) begin errors++; $display("FAIL shadow_err_a got %0b want 0", err_a); end
      checks++; if (err_b !== 1'b0) begin errors++; $display("FAIL shadow_err_b got %0b want 0", err_b); end
`endif
   endtask

   initial begin
      test_reset();
      test_boundary();
      test_bubbles();
      test_reset_midstream();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
